// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake and program-memory write port of the loader.
interface program_loader_if #(
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata
    );
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into 32-bit words written to program memory from address 0.
// Defining LOADER_CHECKSUM_EN adds a trailing checksum word compared against the sum of written words.
module program_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    program_loader_if.slave bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        FIN
    } state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, last;
    logic [1:0]        bcnt;
    logic [23:0]       shreg;
    logic              rej;
    logic              count_ok, take, accept, last_byte;
    logic [31:0]       word;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum;
    logic              sum_ok;
`endif
    assign count_ok  = word_count != '0 && word_count <= MAX_WORDS;
    assign take      = state == IDLE && start && count_ok;
    assign accept    = bus.byte_valid && bus.byte_ready;
    assign last_byte = accept && bcnt == 2'd3;
    assign word      = {shreg, bus.byte_data};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? LOAD : IDLE;
            LOAD:    state_nx = last_byte ? WRITE : LOAD;
`ifdef LOADER_CHECKSUM_EN
            WRITE:   state_nx = idx == last ? CHECK : LOAD;
            CHECK:   state_nx = last_byte ? FIN : CHECK;
`else
            WRITE:   state_nx = idx == last ? FIN : LOAD;
`endif
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Handshake and status are decoded from state only, so byte_valid never reaches byte_ready.
    always_comb begin
        bus.mem_we = state == WRITE;
        busy       = state != IDLE && state != FIN;
        cpu_hold   = busy;
`ifdef LOADER_CHECKSUM_EN
        bus.byte_ready = state == LOAD || state == CHECK;
        done           = state == FIN && sum_ok;
        err            = rej || (state == FIN && !sum_ok);
`else
        bus.byte_ready = state == LOAD;
        done           = state == FIN;
        err            = rej;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            last          <= '0;
            bcnt          <= '0;
            shreg         <= '0;
            rej           <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum           <= '0;
            sum_ok        <= 1'b0;
`endif
        end else begin
            rej <= state == IDLE && start && !count_ok;
            if (take) begin
                last <= ADDR_W'(word_count - 1'b1);
                idx  <= '0;
                bcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum  <= '0;
`endif
            end
            if (accept) begin
                shreg <= {shreg[15:0], bus.byte_data};
                bcnt  <= bcnt + 1'b1;
            end
            // Address and data are captured once per word so they hold between writes.
            if (state == LOAD && last_byte) begin
                bus.mem_waddr <= idx;
                bus.mem_wdata <= word;
            end
            if (state == WRITE && idx != last)
                idx <= idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (state == WRITE)
                sum <= sum + bus.mem_wdata;
            if (state == CHECK && last_byte)
                sum_ok <= word == sum;
`endif
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; stimulus queues expected writes/events, a negedge monitor checks them.
module tb_program_loader;
    localparam int AW = 6;
`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 4;
`else
    localparam int CK = 0;
`endif
    logic clk = 0, rst_n = 0, start = 0;
    logic [AW:0] word_count = '0;
    logic cpu_hold, busy, done, err;
    program_loader_if #(.ADDR_W(AW)) bus ();
    program_loader #(.DEPTH(64), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    int n_cmp = 0, n_bad = 0;
    logic [AW+31:0] exp_w[$];
    logic [1:0] exp_e[$];
    int start_cyc = 0, evt_cyc = 0, first_hold = 0, hold_cnt = 0;
    bit busy_seen = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got unexpected/expired want none", name);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                check("ready_in_write", 64'(bus.byte_ready), 64'd0);
                if (exp_w.size() == 0) fail("unexpected_write");
                else check("write", 64'({bus.mem_waddr, bus.mem_wdata}), 64'(exp_w.pop_front()));
            end
            if (done || err) begin
                evt_cyc = cyc;
                if (exp_e.size() == 0) fail("unexpected_event");
                else check("event", 64'({err, done}), 64'(exp_e.pop_front()));
            end
            if (busy) begin
                if (hold_cnt == 0) first_hold = cyc;
                hold_cnt++;
                busy_seen = 1;
                check("cpu_hold", 64'(cpu_hold), 64'd1);
            end
        end
    end
    task automatic go(input int n);
        @(posedge clk);
        #1;
        word_count = (AW+1)'(n);
        start = 1;
        start_cyc = cyc;
        hold_cnt = 0;
        busy_seen = 0;
        fork
            begin
                @(posedge clk);
                #1;
                start = 0;
            end
        join_none
    endtask
    task automatic send(input logic [7:0] b[$], input bit tog);
        foreach (b[i]) begin
            int k;
            k = 0;
            bus.byte_valid = 1;
            bus.byte_data = b[i];
            while (k < 40) begin
                @(negedge clk);
                k++;
                if (bus.byte_ready) break;
            end
            if (k == 40) fail("byte_timeout");
            @(posedge clk);
            #1;
            if (tog) begin
                bus.byte_valid = 0;
                @(posedge clk);
                #1;
            end
        end
        bus.byte_valid = 0;
    endtask
    task automatic drain();
        int k = 0;
        while ((exp_w.size() != 0 || exp_e.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("drain", 64'(exp_w.size() + exp_e.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask
    task automatic load(input int n, input logic [31:0] w[$], input bit tog, input logic [31:0] delta, input bit extra);
        logic [7:0] b[$];
        logic [31:0] s, t;
        s = 0;
        foreach (w[i]) begin
            t = w[i];
            exp_w.push_back({AW'(i), t});
            s += t;
            for (int j = 3; j >= 0; j--) b.push_back(t[8*j+:8]);
        end
        if (CK != 0) begin
            t = s + delta;
            for (int j = 3; j >= 0; j--) b.push_back(t[8*j+:8]);
        end
        exp_e.push_back((CK != 0 && delta != 0) ? 2'b10 : 2'b01);
        go(n);
        if (extra) fork
            begin
                repeat (3) @(posedge clk);
                #1;
                start = 1;
                word_count = 7'd5;
                @(posedge clk);
                #1;
                start = 0;
            end
        join_none
        send(b, tog);
        drain();
    endtask
    task automatic check_idle(input string name);
        check({name, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check({name, "_we"}, 64'(bus.mem_we), 64'd0);
        check({name, "_waddr"}, 64'(bus.mem_waddr), 64'd0);
        check({name, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({name, "_hold"}, 64'(cpu_hold), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_err"}, 64'(err), 64'd0);
    endtask
    initial begin
        logic [31:0] q[$];
        logic [7:0] b[$];
        bus.byte_valid = 0;
        bus.byte_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1;
        go(1);
        b = {8'h11, 8'h22};
        send(b, 0);
        rst_n = 0;
        #1;
        check_idle("midreset");
        @(posedge clk);
        #1;
        rst_n = 1;
        q = {32'hA1B2C3D4};
        load(1, q, 0, 0, 0);
        q = {32'h12345678, 32'h9ABCDEF0};
        load(2, q, 0, 0, 0);
        check("done_latency", 64'(evt_cyc - start_cyc), 64'(11 + CK));
        check("hold_cycles", 64'(hold_cnt), 64'(10 + CK));
        check("hold_rise", 64'(first_hold - start_cyc), 64'd1);
        exp_e.push_back(2'b10);
        go(0);
        drain();
        check("err0_latency", 64'(evt_cyc - start_cyc), 64'd1);
        check("err0_busy", 64'(busy_seen), 64'd0);
        exp_e.push_back(2'b10);
        go(65);
        drain();
        check("err65_latency", 64'(evt_cyc - start_cyc), 64'd1);
        check("err65_busy", 64'(busy_seen), 64'd0);
        q = {32'hDEADBEEF};
        load(1, q, 1, 0, 0);
        q = {32'hCAFEF00D, 32'h0BADC0DE};
        load(2, q, 0, 0, 1);
        check("restart_hold", 64'(hold_cnt), 64'(10 + CK));
        check("restart_latency", 64'(evt_cyc - start_cyc), 64'(11 + CK));
`ifdef LOADER_CHECKSUM_EN
        q = {32'h00000001, 32'h00000002};
        load(2, q, 0, 0, 0);
        load(2, q, 0, 1, 0);
        check("bad_sum_latency", 64'(evt_cyc - start_cyc), 64'd15);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
